// File: rtl/fetch_pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen_pkg
// Purpose  : Shared types and constants for the IF-stage fetch-PC generator.
// Revision : 1.0  initial release
// ============================================================================
package fetch_pc_gen_pkg;

   typedef logic [31:0] virt_t;

   typedef struct packed {
      logic  valid;
      virt_t data;
   } ras_t;

   typedef enum logic [2:0] {
      PD_NONE     = 3'd0,
      PD_BRANCH   = 3'd1,
      PD_JUMP     = 3'd2,
      PD_CALL_DIR = 3'd3,
      PD_CALL_IND = 3'd4,
      PD_RET      = 3'd5
   } pd_kind_t;

   typedef enum logic [0:0] {
      ST_RUN     = 1'b0,
      ST_WAIT_DS = 1'b1
   } fetch_state_t;

   localparam virt_t       DEF_RESET_PC = 32'hBFC0_0000;
   localparam int unsigned MAX_OUTST    = 2;
   localparam virt_t       INSN_BYTES   = 32'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen_if
// Purpose  : Fetch request/response, predecode, redirect and RAS signal bundle.
// Revision : 1.0  initial release
// ============================================================================
interface fetch_pc_gen_if;
   import fetch_pc_gen_pkg::*;

   logic     fetch_req;
   virt_t    fetch_addr;
   logic     fetch_addr_ok;
   logic     resp_valid;
   virt_t    resp_pc;
   logic     resp_kill;
   pd_kind_t pd_kind;
   virt_t    pd_target;
   logic     redirect_valid;
   virt_t    redirect_pc;
   ras_t     ras_top;
   logic     push_req;
   logic     pop_req;
   virt_t    push_data;
   logic     ras_flush;

   modport master (
      output fetch_req, fetch_addr, resp_pc, resp_kill,
             push_req, pop_req, push_data, ras_flush,
      input  fetch_addr_ok, resp_valid, pd_kind, pd_target,
             redirect_valid, redirect_pc, ras_top
   );

   modport slave (
      input  fetch_req, fetch_addr, resp_pc, resp_kill,
             push_req, pop_req, push_data, ras_flush,
      output fetch_addr_ok, resp_valid, pd_kind, pd_target,
             redirect_valid, redirect_pc, ras_top
   );

endinterface
`default_nettype wire

// File: rtl/fetch_pc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_fifo
// Purpose  : Two-entry FIFO of accepted fetch PCs; its count is the number of
//            outstanding fetches.
// Revision : 1.0  initial release
// ============================================================================
module fetch_pc_fifo
   import fetch_pc_gen_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       push_i,
   input  virt_t      push_pc_i,
   input  logic       pop_i,
   output virt_t      head_pc_o,
   output logic [1:0] count_o
);

   virt_t      mem_q [2];
   logic       rd_ptr_q;
   logic       wr_ptr_q;
   logic [1:0] count_q;

   logic w_do_pop;
   logic w_do_push;

   assign w_do_pop  = pop_i && (count_q != 2'd0);
   assign w_do_push = push_i && ((count_q != 2'd2) || w_do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_pc_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (w_do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, w_do_push} - {1'b0, w_do_pop};
      end
   end

   assign head_pc_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen
// Purpose  : IF-stage fetch-PC generator with delay-slot aware jump/call/return
//            prediction driven by predecode and the return-address stack.
// Revision : 1.0  initial release
// ============================================================================
module fetch_pc_gen
   import fetch_pc_gen_pkg::*;
#(
   parameter virt_t RESET_PC = DEF_RESET_PC
)
(
   input  logic           clk,
   input  logic           reset,
   fetch_pc_gen_if.master fetch_if
);

   fetch_state_t state_q, state_d;
   virt_t        pc_q, pc_d;
   virt_t        tgt_q, tgt_d;
   logic [1:0]   discard_q, discard_d;
   logic         ds_skip_q, ds_skip_d;

   virt_t        head_pc;
   logic [1:0]   outst;

   logic         w_accept;
   logic         w_resp_ok;
   logic         w_consume_ds;
   logic         w_live;
   logic         w_push;
   logic         w_pop;
   logic         w_take;
   virt_t        w_take_tgt;
   logic         w_after_ds;
   logic         w_fetch_req;

   fetch_pc_fifo u_pc_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_i    (w_accept),
      .push_pc_i (pc_q),
      .pop_i     (fetch_if.resp_valid),
      .head_pc_o (head_pc),
      .count_o   (outst)
   );

   // ds_skip_q marks that the next surviving response is the delay slot of a
   // taken redirect; its predecode is ignored wherever it lands in time.
   assign w_resp_ok    = fetch_if.resp_valid && (discard_q == 2'd0) && !fetch_if.redirect_valid;
   assign w_consume_ds = w_resp_ok && ds_skip_q;
   assign w_live       = w_resp_ok && !ds_skip_q && (state_q == ST_RUN);
   assign w_after_ds   = (pc_q == head_pc + 32'd8);

   always_comb begin
      w_push     = 1'b0;
      w_pop      = 1'b0;
      w_take     = 1'b0;
      w_take_tgt = fetch_if.pd_target;
      if (w_live) begin
         unique case (fetch_if.pd_kind)
            PD_CALL_DIR: begin
               w_push = 1'b1;
               w_take = 1'b1;
            end
            PD_CALL_IND: w_push = 1'b1;
            PD_JUMP:     w_take = 1'b1;
            PD_RET: begin
               w_pop      = 1'b1;
               w_take     = fetch_if.ras_top.valid;
               w_take_tgt = fetch_if.ras_top.data;
            end
            default: ;
         endcase
      end
   end

   // With the delay slot already requested, P+8 is held back so the wrong-path
   // word is never accepted and the in-order discard count stays exact.
   assign w_fetch_req = !reset && !fetch_if.redirect_valid && !(w_take && w_after_ds) &&
                        ((outst < 2'(MAX_OUTST)) || fetch_if.resp_valid);
   assign w_accept    = w_fetch_req && fetch_if.fetch_addr_ok;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      tgt_d     = tgt_q;
      discard_d = discard_q;
      ds_skip_d = ds_skip_q;

      if (fetch_if.resp_valid && (discard_q != 2'd0)) begin
         discard_d = discard_q - 2'd1;
      end
      if (w_accept) begin
         pc_d = pc_q + INSN_BYTES;
         if (state_q == ST_WAIT_DS) begin
            pc_d    = tgt_q;
            state_d = ST_RUN;
         end
      end
      if (w_consume_ds) begin
         ds_skip_d = 1'b0;
      end
      if (w_take) begin
         ds_skip_d = 1'b1;
         if (w_after_ds || w_accept) begin
            pc_d = w_take_tgt;
         end else begin
            state_d = ST_WAIT_DS;
            tgt_d   = w_take_tgt;
         end
      end
      if (fetch_if.redirect_valid) begin
         pc_d      = fetch_if.redirect_pc;
         state_d   = ST_RUN;
         ds_skip_d = 1'b0;
         discard_d = outst - {1'b0, fetch_if.resp_valid};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_RUN;
         pc_q      <= RESET_PC;
         tgt_q     <= '0;
         discard_q <= 2'd0;
         ds_skip_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         tgt_q     <= tgt_d;
         discard_q <= discard_d;
         ds_skip_q <= ds_skip_d;
      end
   end

   assign fetch_if.fetch_req  = w_fetch_req;
   assign fetch_if.fetch_addr = pc_q;
   assign fetch_if.resp_pc    = head_pc;
   assign fetch_if.resp_kill  = fetch_if.resp_valid && (discard_q != 2'd0);
   assign fetch_if.push_req   = w_push;
   assign fetch_if.pop_req    = w_pop;
   assign fetch_if.push_data  = w_push ? (head_pc + 32'd8) : '0;
   assign fetch_if.ras_flush  = fetch_if.redirect_valid;

   a_take_pc_known: assert property (@(posedge clk) disable iff (reset)
      w_take |-> ((pc_q == head_pc + INSN_BYTES) || w_after_ds));
   a_resp_has_outst: assert property (@(posedge clk) disable iff (reset)
      fetch_if.resp_valid |-> (outst != 2'd0));

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_gen
// Purpose  : Randomized scoreboard bench for fetch_pc_gen against a path-level
//            model of a hashed synthetic program.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_pc_gen;
   import fetch_pc_gen_pkg::*;

   localparam virt_t TB_RESET_PC = 32'hBFC0_0000;
   localparam int EV_NONE = 0;
   localparam int EV_PUSH = 1;
   localparam int EV_POP  = 2;

   typedef struct {
      virt_t addr;
      int    ev;
      virt_t data;
   } exp_t;

   logic clk;
   logic reset;
   fetch_pc_gen_if bus ();

   fetch_pc_gen #(.RESET_PC(TB_RESET_PC)) dut (
      .clk      (clk),
      .reset    (reset),
      .fetch_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_tests = 0;
   int    n_fail  = 0;
   logic [31:0] seed;

   // environment: memory in-flight list and the return-address stack
   virt_t env_infl[$];
   virt_t env_ras[$];

   // reference model: architectural fetch path
   virt_t m_pc;
   logic  m_ds;
   virt_t m_ds_tgt;
   virt_t m_ras[$];

   exp_t  exp_q[$];
   exp_t  sb_infl[$];
   int    kill_cnt;
   int    idle_cycles;
   logic  rst_seen;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] hsh(input logic [31:0] a);
      logic [31:0] x;
      x = a ^ seed;
      x = x * 32'h9E37_79B1;
      x = x ^ (x >> 15);
      x = x * 32'h85EB_CA6B;
      x = x ^ (x >> 13);
      return x;
   endfunction

   function automatic pd_kind_t kind_at(input virt_t a);
      logic [31:0] r;
      r = hsh(a) % 100;
      if (r < 6)       return PD_CALL_DIR;
      else if (r < 9)  return PD_CALL_IND;
      else if (r < 14) return PD_JUMP;
      else if (r < 22) return PD_RET;
      else if (r < 27) return PD_BRANCH;
      return PD_NONE;
   endfunction

   function automatic virt_t target_at(input virt_t a);
      return 32'h8000_0000 | (hsh(a ^ 32'h5A5A_5A5A) & 32'h0000_3FFC);
   endfunction

   task automatic model_step(output exp_t e);
      pd_kind_t k;
      logic     take;
      virt_t    t;
      e.addr = m_pc;
      e.ev   = EV_NONE;
      e.data = '0;
      if (m_ds) begin
         m_ds = 1'b0;
         m_pc = m_ds_tgt;
      end else begin
         k    = kind_at(m_pc);
         t    = target_at(m_pc);
         take = 1'b0;
         case (k)
            PD_CALL_DIR: begin
               e.ev = EV_PUSH; e.data = m_pc + 8; m_ras.push_back(m_pc + 8); take = 1'b1;
            end
            PD_CALL_IND: begin
               e.ev = EV_PUSH; e.data = m_pc + 8; m_ras.push_back(m_pc + 8);
            end
            PD_JUMP: take = 1'b1;
            PD_RET: begin
               e.ev = EV_POP;
               if (m_ras.size() > 0) begin
                  t    = m_ras.pop_back();
                  take = 1'b1;
               end
            end
            default: ;
         endcase
         if (take) begin
            m_ds     = 1'b1;
            m_ds_tgt = t;
         end
         m_pc = m_pc + 4;
      end
   endtask

   task automatic refill(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         model_step(e);
         exp_q.push_back(e);
      end
   endtask

   task automatic model_restart(input virt_t a);
      m_pc = a;
      m_ds = 1'b0;
      m_ras.delete();
      exp_q.delete();
      refill(16);
   endtask

   // environment bookkeeping
   always @(negedge clk) begin
      if (reset) begin
         env_infl.delete();
         env_ras.delete();
      end else begin
         if (bus.ras_flush) begin
            env_ras.delete();
         end else begin
            if (bus.push_req) env_ras.push_back(bus.push_data);
            if (bus.pop_req && env_ras.size() > 0) void'(env_ras.pop_back());
         end
         if (bus.resp_valid && env_infl.size() > 0) void'(env_infl.pop_front());
         if (bus.fetch_req && bus.fetch_addr_ok) env_infl.push_back(bus.fetch_addr);
      end
   end

   // monitor / scoreboard
   exp_t e;
   logic ek;
   logic live;
   always @(negedge clk) begin
      if (reset) begin
         if (!rst_seen) begin
            chk("rst_fetch_addr", bus.fetch_addr, TB_RESET_PC);
            chk("rst_fetch_req",  32'(bus.fetch_req), 32'd0);
            chk("rst_push_pop",   {30'd0, bus.push_req, bus.pop_req}, 32'd0);
            chk("rst_flush_kill", {30'd0, bus.ras_flush, bus.resp_kill}, 32'd0);
            chk("rst_push_data",  bus.push_data, 32'd0);
         end
         rst_seen    = 1'b1;
         sb_infl.delete();
         kill_cnt    = 0;
         idle_cycles = 0;
         model_restart(TB_RESET_PC);
      end else begin
         rst_seen = 1'b0;
         chk("ras_flush", 32'(bus.ras_flush), 32'(bus.redirect_valid));
         if (bus.redirect_valid) chk("req_on_redirect", 32'(bus.fetch_req), 32'd0);
         if (bus.resp_valid) begin
            if (sb_infl.size() == 0) begin
               chk("resp_without_fetch", 32'd1, 32'd0);
            end else begin
               e = sb_infl.pop_front();
               chk("resp_pc", bus.resp_pc, e.addr);
               ek = (kill_cnt > 0);
               chk("resp_kill", 32'(bus.resp_kill), 32'(ek));
               if (ek) kill_cnt--;
               live = !ek && !bus.redirect_valid;
               chk("push_req", 32'(bus.push_req), 32'(live && e.ev == EV_PUSH));
               chk("pop_req",  32'(bus.pop_req),  32'(live && e.ev == EV_POP));
               if (live && e.ev == EV_PUSH) chk("push_data", bus.push_data, e.data);
            end
         end else begin
            chk("push_pop_idle", {30'd0, bus.push_req, bus.pop_req}, 32'd0);
         end
         if (bus.fetch_req && bus.fetch_addr_ok) begin
            if (exp_q.size() < 4) refill(16);
            e = exp_q.pop_front();
            chk("fetch_addr", bus.fetch_addr, e.addr);
            sb_infl.push_back(e);
            chk("outst_le_2", 32'(sb_infl.size() <= 2), 32'd1);
            idle_cycles = 0;
         end else begin
            idle_cycles++;
            if (idle_cycles == 200) chk("fetch_progress_timeout", 32'd1, 32'd0);
         end
         if (bus.redirect_valid) begin
            kill_cnt = sb_infl.size();
            model_restart(bus.redirect_pc);
         end
      end
   end

   task automatic drive_idle();
      bus.fetch_addr_ok  = 1'b0;
      bus.resp_valid     = 1'b0;
      bus.pd_kind        = PD_NONE;
      bus.pd_target      = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.ras_top.valid  = 1'b0;
      bus.ras_top.data   = '0;
   endtask

   task automatic drive_cycle(input int ok_pct, input int resp_pct, input int redir_pct);
      int    p;
      virt_t a;
      bus.fetch_addr_ok = ($urandom_range(99) < ok_pct);
      bus.resp_valid    = (env_infl.size() > 0) && ($urandom_range(99) < resp_pct);
      if (bus.resp_valid) begin
         a             = env_infl[0];
         bus.pd_kind   = kind_at(a);
         bus.pd_target = target_at(a);
      end else begin
         bus.pd_kind   = PD_NONE;
         bus.pd_target = $urandom & 32'hFFFF_FFFC;
      end
      bus.ras_top.valid = (env_ras.size() > 0);
      bus.ras_top.data  = (env_ras.size() > 0) ? env_ras[$] : ($urandom & 32'hFFFF_FFFC);
      p = redir_pct;
      if (bus.resp_valid && bus.pd_kind == PD_CALL_DIR && redir_pct > 0) p = redir_pct * 10;
      bus.redirect_valid = ($urandom_range(99) < p);
      bus.redirect_pc    = 32'h8000_0000 | ($urandom & 32'h0000_3FFC);
   endtask

   int ok_tab    [4] = '{100, 70, 80, 50};
   int resp_tab  [4] = '{100, 50, 60, 40};
   int redir_tab [4] = '{0, 0, 3, 2};
   int len_tab   [4] = '{300, 1500, 1500, 1500};

   initial begin
      seed     = $urandom;
      rst_seen = 1'b0;
      reset    = 1'b1;
      drive_idle();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      for (int ph = 0; ph < 4; ph++) begin
         for (int c = 0; c < len_tab[ph]; c++) begin
            if (ph == 2 && c == len_tab[ph] / 2) begin
               reset = 1'b1;
               drive_idle();
               repeat (2) @(posedge clk);
               #1 reset = 1'b0;
            end
            drive_cycle(ok_tab[ph], resp_tab[ph], redir_tab[ph]);
            @(posedge clk);
            #1;
         end
      end
      drive_idle();
      repeat (4) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
